// File: rtl/apb_master_ctrl_if.sv
// Request/response and APB signal bundle shared by apb_master_ctrl and its environment.
// The master modport is the controller's view. The slave modport is the view of
// the request source and APB stage that surround it.
interface apb_master_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        pwrite;
  logic        penable;
  logic [2:0]  psel;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, pwrite, penable, psel, paddr, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, pwrite, penable, psel, paddr, pwdata
  );
endinterface

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: turns single-beat requests into APB SETUP/ACCESS transfers.
// It decodes the request address to one of three peripheral selects.
// Optional feature macro: APB_TIMEOUT_EN. When it is defined, the controller
// aborts an ACCESS phase after TIMEOUT consecutive wait cycles.
//
// state  | meaning
// IDLE   | ready for a request; rsp_valid pulses here after a transfer
// SETUP  | psel driven, penable low
// ACCESS | penable high, waiting for pready
// DERR   | address missed every peripheral; error response follows
module apb_master_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic               hclk_i,
  input logic               hreset_i,
  apb_master_ctrl_if.master bus_if
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DERR} state_e;

  state_e      state_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;
  logic        pwrite_q;
  logic        penable_q;
  logic [2:0]  psel_q;
  logic [31:0] paddr_q;
  logic [31:0] pwdata_q;
  logic [2:0]  sel_dec;

`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] TimeoutC = 8'(TIMEOUT);
  logic [7:0] wait_cnt_q;
`else
  // Keeps the parameter referenced when the timeout is compiled out.
  logic unused_timeout;
  assign unused_timeout = ^8'(TIMEOUT);
`endif

  // Each peripheral owns a 64 MiB window starting at 0x8000_0000.
  always_comb begin
    sel_dec = 3'b000;
    case (bus_if.req_addr[31:26])
      6'h20:   sel_dec = 3'b001;
      6'h21:   sel_dec = 3'b010;
      6'h22:   sel_dec = 3'b100;
      default: sel_dec = 3'b000;
    endcase
  end

  // Transfer sequencer with registered APB and response outputs.
  always_ff @(posedge hclk_i) begin
    if (hreset_i) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      pwrite_q    <= 1'b0;
      penable_q   <= 1'b0;
      psel_q      <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus_if.req_valid) begin
            if (sel_dec != 3'b000) begin
              state_q   <= SETUP;
              psel_q    <= sel_dec;
              penable_q <= 1'b0;
              pwrite_q  <= bus_if.req_write;
              paddr_q   <= bus_if.req_addr;
              pwdata_q  <= bus_if.req_write ? bus_if.req_wdata : 32'h0;
            end else begin
              state_q <= DERR;
            end
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
`ifdef APB_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end
        ACCESS: begin
          // pready takes priority over a timeout that would fire in the same cycle.
          if (bus_if.pready) begin
            state_q     <= IDLE;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= bus_if.pslverr;
            rsp_rdata_q <= pwrite_q ? 32'h0 : bus_if.prdata;
          end
`ifdef APB_TIMEOUT_EN
          else if (wait_cnt_q == TimeoutC - 8'd1) begin
            state_q     <= IDLE;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
`endif
        end
        DERR: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b1;
          rsp_rdata_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_if.req_ready = (state_q == IDLE);
  assign bus_if.rsp_valid = rsp_valid_q;
  assign bus_if.rsp_err   = rsp_err_q;
  assign bus_if.rsp_rdata = rsp_rdata_q;
  assign bus_if.pwrite    = pwrite_q;
  assign bus_if.penable   = penable_q;
  assign bus_if.psel      = psel_q;
  assign bus_if.paddr     = paddr_q;
  assign bus_if.pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl: directed scenarios followed by random requests,
// all checked every cycle against a transaction-level timeline model.
module tb_apb_master_ctrl;
  localparam int TO = 4;
`ifdef APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  apb_master_ctrl_if bus ();
  apb_master_ctrl #(.TIMEOUT(TO)) dut (.hclk_i(clk), .hreset_i(rst), .bus_if(bus.master));
  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    int          gap;
    bit          w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    bit          slverr;
    int          waits;
    int          rst_k;
  } rec_t;

  rec_t q[$];
  rec_t cur;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gap_left = 0;

  // transaction-level model
  bit          m_busy = 1'b0;
  int          m_k = 0, m_acc = 0, m_L = 0;
  bit          m_hit, m_w, m_to;
  logic [31:0] m_addr, m_wd;
  logic [2:0]  m_sel;
  logic [31:0] m_paddr = '0, m_rdata = '0;
  bit          m_err = 1'b0;
  int          pen_cnt = 0;
  bit          last_rv = 1'b0, acc_prev_rv = 1'b0, rst_hit6 = 1'b0;

  // driven inputs
  bit d_rst, d_valid, d_write, d_pready, d_slverr;
  logic [31:0] d_addr, d_wdata, d_prdata;

  logic [31:0] bnd [8] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h83FF_FFFF, 32'h8400_0000,
                           32'h87FF_FFFF, 32'h8800_0000, 32'h8BFF_FFFF, 32'h8C00_0000};

  function automatic logic [2:0] decode(logic [31:0] a);
    if (a >= 32'h8000_0000 && a <= 32'h83FF_FFFF) return 3'b001;
    if (a >= 32'h8400_0000 && a <= 32'h87FF_FFFF) return 3'b010;
    if (a >= 32'h8800_0000 && a <= 32'h8BFF_FFFF) return 3'b100;
    return 3'b000;
  endfunction

  function automatic rec_t mk(int tag, int gap, bit w, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] prdata, bit slverr, int waits, int rst_k);
    rec_t r;
    r.tag = tag; r.gap = gap; r.w = w; r.addr = addr; r.wdata = wdata;
    r.prdata = prdata; r.slverr = slverr; r.waits = waits; r.rst_k = rst_k;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic apply_inputs();
    rst = d_rst;
    bus.req_valid = d_valid;
    bus.req_write = d_write;
    bus.req_addr = d_addr;
    bus.req_wdata = d_wdata;
    bus.pready = d_pready;
    bus.prdata = d_prdata;
    bus.pslverr = d_slverr;
  endtask

  // Advance the model across one rising edge using the inputs that were driven into it.
  task automatic model_edge();
    bit idle_vis;
    idle_vis = !m_busy || (m_k == m_L);
    if (d_rst) begin
      if (m_busy && cur.tag == 6) rst_hit6 = 1'b1;
      m_busy = 1'b0; m_err = 1'b0; m_rdata = '0; m_paddr = '0;
    end else if (!idle_vis) begin
      if (!m_hit) begin
        m_err = 1'b1; m_rdata = '0;
      end else if (m_k == m_acc) begin
        if (m_to) begin
          m_err = 1'b1; m_rdata = '0;
        end else begin
          m_err = d_slverr; m_rdata = m_w ? 32'h0 : d_prdata;
        end
      end
      m_k++;
    end else if (d_valid) begin
      acc_prev_rv = last_rv;
      cur = q.pop_front();
      m_w = d_write; m_addr = d_addr; m_wd = d_wdata;
      m_sel = decode(d_addr);
      m_hit = (m_sel != 3'b000);
      if (m_hit) m_paddr = d_addr;
      m_to = TO_EN && (cur.waits >= TO);
      m_acc = m_to ? TO : cur.waits + 1;
      m_L = m_hit ? m_acc + 1 : 1;
      m_k = 0;
      m_busy = 1'b1;
      pen_cnt = 0;
      gap_left = (q.size() > 0) ? q[0].gap : 0;
    end else begin
      m_busy = 1'b0;
    end
  endtask

  task automatic compare_all();
    bit in_xfer, e_ready, e_rv, e_pen, e_pw;
    logic [2:0] e_psel;
    logic [31:0] e_pwd;
    in_xfer = m_busy && (m_k < m_L);
    e_ready = !in_xfer;
    e_rv = m_busy && (m_k == m_L);
    e_psel = 3'b000; e_pen = 1'b0; e_pw = 1'b0; e_pwd = '0;
    if (in_xfer && m_hit) begin
      e_psel = m_sel; e_pen = (m_k >= 1); e_pw = m_w; e_pwd = m_w ? m_wd : 32'h0;
    end
    chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
    chk("rsp_err", 32'(bus.rsp_err), 32'(m_err));
    chk("rsp_rdata", bus.rsp_rdata, m_rdata);
    chk("psel", 32'(bus.psel), 32'(e_psel));
    chk("penable", 32'(bus.penable), 32'(e_pen));
    chk("pwrite", 32'(bus.pwrite), 32'(e_pw));
    chk("paddr", bus.paddr, m_paddr);
    if (e_psel != 3'b000) chk("pwdata", bus.pwdata, e_pwd);
  endtask

  // Literal expectations for the directed scenarios; these pin the model itself.
  task automatic directed_checks();
    if (cyc == 1) begin
      chk("reset_ready", 32'(bus.req_ready), 32'd1);
      chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
      chk("reset_psel", 32'(bus.psel), 32'd0);
      chk("reset_paddr", bus.paddr, 32'h0);
      chk("reset_pwdata", bus.pwdata, 32'h0);
    end
    if (rst_hit6) begin
      rst_hit6 = 1'b0;
      chk("midrst_ready", 32'(bus.req_ready), 32'd1);
      chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("midrst_psel", 32'(bus.psel), 32'd0);
      chk("midrst_penable", 32'(bus.penable), 32'd0);
      chk("midrst_paddr", bus.paddr, 32'h0);
      chk("midrst_pwdata", bus.pwdata, 32'h0);
    end
    if (!m_busy) return;
    case (cur.tag)
      1: begin
        if (m_k == 0) begin
          chk("zw_psel", 32'(bus.psel), 32'd1);
          chk("zw_pen_setup", 32'(bus.penable), 32'd0);
          chk("zw_pwdata", bus.pwdata, 32'hDEAD_BEEF);
        end
        if (m_k == 1) chk("zw_pen_access", 32'(bus.penable), 32'd1);
        if (m_k == 2) begin
          chk("zw_rsp_valid", 32'(bus.rsp_valid), 32'd1);
          chk("zw_rsp_err", 32'(bus.rsp_err), 32'd0);
          chk("zw_rsp_rdata", bus.rsp_rdata, 32'h0);
        end
      end
      2: begin
        if (m_k == 1) chk("rw_psel", 32'(bus.psel), 32'd2);
        if (m_k == 4) begin
          chk("rw_rsp_valid", 32'(bus.rsp_valid), 32'd1);
          chk("rw_rsp_rdata", bus.rsp_rdata, 32'h0000_00A5);
          chk("rw_rsp_err", 32'(bus.rsp_err), 32'd0);
          chk("rw_access_cycles", 32'(pen_cnt), 32'd3);
        end
      end
      3: begin
        if (m_k == 0) chk("miss_psel", 32'(bus.psel), 32'd0);
        if (m_k == 1) begin
          chk("miss_rsp_valid", 32'(bus.rsp_valid), 32'd1);
          chk("miss_rsp_err", 32'(bus.rsp_err), 32'd1);
        end
      end
      4: begin
        if (m_k == 0) chk("b2b1_psel", 32'(bus.psel), 32'd4);
        if (m_k == 2) begin
          chk("b2b1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
          chk("b2b1_rsp_err", 32'(bus.rsp_err), 32'd1);
        end
      end
      5: begin
        if (m_k == 0) begin
          chk("b2b2_psel", 32'(bus.psel), 32'd1);
          chk("b2b2_accept_with_rsp", 32'(acc_prev_rv), 32'd1);
        end
      end
      7: begin
        if (m_k == (TO_EN ? TO + 1 : 12)) begin
          chk("long_rsp_valid", 32'(bus.rsp_valid), 32'd1);
          chk("long_access_cycles", 32'(pen_cnt), TO_EN ? 32'(TO) : 32'd11);
          chk("long_rsp_err", 32'(bus.rsp_err), TO_EN ? 32'd1 : 32'(cur.slverr));
          if (TO_EN) chk("long_rsp_rdata", bus.rsp_rdata, 32'h0);
        end
      end
      default: ;
    endcase
  endtask

  task automatic choose_inputs();
    bit idle_vis, in_access, completing;
    idle_vis = !m_busy || (m_k == m_L);
    in_access = m_busy && m_hit && (m_k >= 1) && (m_k <= m_acc);
    completing = in_access && (m_k == cur.waits + 1);
    d_rst = (cyc < 2);
    if (in_access && cur.rst_k == m_k) d_rst = 1'b1;
    d_pready = in_access ? completing : 1'($urandom_range(0, 1));
    d_prdata = completing ? cur.prdata : $urandom();
    d_slverr = completing ? cur.slverr : 1'($urandom_range(0, 1));
    if (idle_vis && q.size() > 0 && gap_left == 0) begin
      d_valid = 1'b1; d_write = q[0].w; d_addr = q[0].addr; d_wdata = q[0].wdata;
    end else begin
      d_valid = idle_vis ? 1'b0 : 1'($urandom_range(0, 1));
      d_write = 1'($urandom_range(0, 1));
      d_addr = $urandom();
      d_wdata = $urandom();
      if (idle_vis && gap_left > 0) gap_left--;
    end
  endtask

  initial begin
    logic [31:0] a;
    q.push_back(mk(1, 1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 0, -1));
    q.push_back(mk(2, 1, 1'b0, 32'h8400_0004, 32'h5555_5555, 32'h0000_00A5, 1'b0, 2, -1));
    q.push_back(mk(3, 1, 1'b0, 32'h9000_0000, 32'h0, 32'h0, 1'b0, 0, -1));
    q.push_back(mk(4, 1, 1'b1, 32'h8800_0000, 32'hCAFE_0001, 32'h0, 1'b1, 0, -1));
    q.push_back(mk(5, 0, 1'b1, 32'h8000_0000, 32'hCAFE_0002, 32'h0, 1'b0, 0, -1));
    q.push_back(mk(6, 1, 1'b0, 32'h8000_0100, 32'h0, 32'h0000_0077, 1'b0, 5, 2));
    q.push_back(mk(7, 1, 1'b0, 32'h8400_0000, 32'h0, 32'hABCD_0000, 1'b1, 10, -1));
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0: a = 32'h8000_0000 + ($urandom() & 32'h03FF_FFFF);
        1: a = 32'h8400_0000 + ($urandom() & 32'h03FF_FFFF);
        2: a = 32'h8800_0000 + ($urandom() & 32'h03FF_FFFF);
        3, 4: a = bnd[$urandom_range(0, 7)];
        default: a = $urandom();
      endcase
      q.push_back(mk(100 + i, $urandom_range(0, 2), 1'($urandom_range(0, 1)), a, $urandom(),
                     $urandom(), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3), -1));
    end
    gap_left = q[0].gap;
    cur = q[0];
    choose_inputs();
    while ((q.size() > 0 || m_busy || cyc < 4) && cyc < 20000) begin
      apply_inputs();
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      compare_all();
      if (m_busy && bus.penable) pen_cnt++;
      directed_checks();
      last_rv = bus.rsp_valid;
      choose_inputs();
    end
    if (cyc >= 20000) begin
      errors++;
      $display("FAIL run_bound cyc=%0d actual=%0d queued expected=0", cyc, q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
